cdc_handshake_tx: RTL and testbench

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

---
 rtl/cdc_pkg.sv | 13 +
 rtl/sync_bit.sv | 23 ++
 rtl/cdc_handshake_tx.sv | 110 +++++++++++
 tb/tb_cdc_handshake_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the toggle-handshake CDC transmitter and its receiver.
package cdc_pkg;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StWaitAck = 1'b1
    } tx_state_e;

    localparam int unsigned DefaultDataW      = 8;
    localparam int unsigned DefaultSyncStages = 2;
    localparam int unsigned TimeoutCntW       = 16;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer; shared by the CDC transmitter and receiver.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase (toggle) req/ack CDC handshake carrying one payload per transfer.
// Optional ack watchdog enabled by defining CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_W         = DefaultDataW,
    parameter int unsigned SYNC_STAGES    = DefaultSyncStages,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack,
    output logic              busy,
    output logic              timeout_err
);

    tx_state_e         state_q;
    logic              in_ready_q;
    logic              xfer_req_q;
    logic [DATA_W-1:0] xfer_data_q;
    logic              ack_s;
    logic              accept;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .reset(reset),
        .d    (xfer_ack),
        .q    (ack_s)
    );

    assign accept = (state_q == StIdle) && in_ready_q && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // in_ready stays low out of reset until the first edge.
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (accept) begin
                        xfer_data_q <= in_data;
                        xfer_req_q  <= ~xfer_req_q;
                        in_ready_q  <= 1'b0;
                        state_q     <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (ack_s == xfer_req_q) begin
                        in_ready_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign xfer_req  = xfer_req_q;
    assign xfer_data = xfer_data_q;
    assign busy      = (state_q != StIdle);

`ifdef CDC_TX_TIMEOUT_EN
    localparam logic [TimeoutCntW:0] TimeoutLimit = TIMEOUT_CYCLES[TimeoutCntW:0];

    logic [TimeoutCntW-1:0] tmo_cnt_q;
    logic [TimeoutCntW:0]   tmo_cnt_inc;
    logic                   timeout_err_q;

    assign tmo_cnt_inc = {1'b0, tmo_cnt_q} + {{TimeoutCntW{1'b0}}, 1'b1};

    // Watchdog only flags; the FSM keeps waiting for the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else if (accept) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StWaitAck) begin
            if (!tmo_cnt_inc[TimeoutCntW]) begin
                tmo_cnt_q <= tmo_cnt_inc[TimeoutCntW-1:0];
            end
            if (tmo_cnt_inc >= TimeoutLimit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: transaction-level model predicts outputs, monitor compares.
module tb_cdc_handshake_tx;

    localparam int unsigned DW  = 8;
    localparam int unsigned SS  = 2;
    localparam int unsigned TMO = 16;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          xfer_ack = 1'b0;
    logic          in_ready;
    logic          xfer_req;
    logic [DW-1:0] xfer_data;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    cdc_handshake_tx #(
        .DATA_W        (DW),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .xfer_req   (xfer_req),
        .xfer_data  (xfer_data),
        .xfer_ack   (xfer_ack),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic          ready;
        logic          busy;
        logic          req;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [DW:0]  xfer_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           edge_cnt = 0;

    // Transaction-level model of the transmitter and of the destination responder.
    bit            m_ready, m_busy, m_req, m_err, m_acc, acked;
    logic [DW-1:0] m_data;
    int            m_wait, done_at, ack_dly;
    int            force_dly = -1;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 0; m_busy = 0; m_req = 0; m_err = 0; m_acc = 0; acked = 0;
        m_data = '0; m_wait = 0; done_at = -1; ack_dly = 0;
        exp_q.delete();
        xfer_q.delete();
    endtask

    // Predict outputs after the coming edge given the inputs now driven.
    task automatic predict(input bit v, input logic [DW-1:0] d);
        bit pre_busy;
        pre_busy = m_busy;
        m_acc = 0;
`ifdef CDC_TX_TIMEOUT_EN
        if (pre_busy) begin
            m_wait++;
            if (m_wait >= TMO) m_err = 1;
        end
`endif
        if (!m_busy && !m_ready) begin
            m_ready = 1;
        end else if (!m_busy && v) begin
            m_req   = ~m_req;
            m_data  = d;
            m_ready = 0;
            m_busy  = 1;
            m_acc   = 1;
            m_wait  = 0;
            acked   = 0;
            ack_dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 5));
            xfer_q.push_back({m_req, d});
        end else if (m_busy && acked && (edge_cnt + 1 == done_at)) begin
            // Ack seen by the sync chain SS edges after its toggle, one more edge to finish.
            m_busy  = 0;
            m_ready = 1;
        end
        exp_q.push_back('{ready: m_ready, busy: m_busy, req: m_req, err: m_err, data: m_data});
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (m_busy && !acked) begin
            if (ack_dly == 0) begin
                xfer_ack = m_req;
                acked    = 1;
                done_at  = edge_cnt + SS + 1;
            end else begin
                ack_dly--;
            end
        end
        predict(v, d);
    endtask

    task automatic send(input logic [DW-1:0] d);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, d);
            if (m_acc) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_accept: payload 0x%0h not accepted within 60 cycles", d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_xfer_req"}, xfer_req, 0);
        chk({tag, "_xfer_data"}, xfer_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // Monitor: per-edge output check plus a data check on every req toggle.
    logic prev_req = 1'b0;
    always @(posedge clk) begin : monitor
        exp_t        e;
        logic [DW:0] x;
        #1;
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("in_ready", in_ready, e.ready);
                chk("busy", busy, e.busy);
                chk("xfer_req", xfer_req, e.req);
                chk("timeout_err", timeout_err, e.err);
                chk("xfer_data", xfer_data, e.data);
            end
            if (xfer_req !== prev_req) begin
                if (xfer_q.size() > 0) begin
                    x = xfer_q.pop_front();
                    chk("toggle_payload", {xfer_req, xfer_data}, x);
                end else begin
                    chk("spurious_toggle", xfer_req, prev_req);
                end
            end
            prev_req = xfer_req;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("in_reset");

        // Release: in_ready expected high after the first edge.
        @(negedge clk);
        reset = 1'b0;
        predict(1'b0, '0);
        idle(2);

        // Single transfer with immediate ack.
        force_dly = 0;
        send(8'hA5);
        idle(6);

        // Back-to-back with held valid.
        force_dly = -1;
        send(8'h11);
        send(8'h22);
        idle(8);

        // Input churn during WAIT_ACK.
        force_dly = 4;
        send(8'h3C);
        for (int i = 0; i < 40 && m_busy; i++) cycle(1'b1, DW'($urandom));
        force_dly = -1;
        idle(10);

        // Spurious ack toggle while idle must be ignored.
        cycle(1'b0, '0);
        xfer_ack = ~xfer_ack;
        idle(4);
        xfer_ack = ~xfer_ack;
        idle(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) cycle($urandom_range(0, 3) != 0, DW'($urandom));
        idle(10);

        // Withheld ack: watchdog flag (when built) is sticky through a late ack.
        force_dly = 24;
        send(8'h5A);
        idle(36);
        force_dly = -1;
        send(8'h77);
        idle(10);

        // Reset mid-transfer: outputs clear without a clock edge.
        force_dly = 30;
        send(8'hC3);
        idle(3);
        @(negedge clk);
        #2;
        reset    = 1'b1;
        xfer_ack = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        predict(1'b0, '0);
        force_dly = -1;
        send(8'h96);
        idle(10);

        @(posedge clk);
        #2;
        chk("unobserved_transfers", xfer_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
